// File: rtl/tsal_controller.sv
// TSAL sequencing controller: synchronises and debounces the HV-present, AIR-closed
// and sense-wire inputs, runs the power-up lamp test, watches HV/AIR plausibility
// and drives the red/green enables of the pulse generator. Faults latch with both
// lamps dark until an explicit, qualified clear.
module tsal_controller #(
    parameter int DEBOUNCE_CYCLES = 8000,
    parameter int LAMP_CYCLES     = 800000,
    parameter int PLAUS_CYCLES    = 40000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hv_present,
    input  logic       air_closed,
    input  logic       sense_ok,
    input  logic       fault_clr,
    output logic       red_ctrl,
    output logic       green_ctrl,
    output logic       fault,
    output logic [1:0] state
);

    localparam int NUM_IN = 3;
    localparam int HV     = 0;
    localparam int AIR    = 1;
    localparam int SNS    = 2;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LC_W   = $clog2(LAMP_CYCLES + 1);
    localparam int PC_W   = $clog2(PLAUS_CYCLES + 1);

    typedef enum logic [1:0] {
        S_LAMP   = 2'b00,
        S_SAFE   = 2'b01,
        S_ACTIVE = 2'b10,
        S_FAULT  = 2'b11
    } state_t;

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] r_sync1;
    logic [NUM_IN-1:0] r_sync2;
    logic [NUM_IN-1:0] r_db;
    logic [DB_W-1:0]   r_dbcnt [NUM_IN];
    logic [LC_W-1:0]   r_lamp_cnt;
    logic [PC_W-1:0]   r_pc;
    state_t            r_state;
    state_t            w_next;
    logic              w_mismatch;
    logic              w_pc_hit;
    logic              w_run;

    assign w_raw      = {sense_ok, air_closed, hv_present};
    assign w_mismatch = r_db[HV] != r_db[AIR];
    assign w_run      = (r_state == S_SAFE) || (r_state == S_ACTIVE);
    // Fault fires on the cycle the counter would reach the limit, so the state
    // changes right after exactly PLAUS_CYCLES mismatched cycles.
    assign w_pc_hit   = w_mismatch && (r_pc >= PC_W'(PLAUS_CYCLES - 1));
    assign state      = r_state;

    // Two-flop synchronisers for the asynchronous sense inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncers: accept the synced value after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db <= '0;
            for (int i = 0; i < NUM_IN; i++) r_dbcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_dbcnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db[i]    <= r_sync2[i];
                        r_dbcnt[i] <= '0;
                    end else begin
                        r_dbcnt[i] <= r_dbcnt[i] + DB_W'(1);
                    end
                end else begin
                    r_dbcnt[i] <= '0;
                end
            end
        end
    end

    // Lamp-test timer: runs only while in LAMP, parks at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lamp_cnt <= '0;
        end else if (r_state != S_LAMP) begin
            r_lamp_cnt <= '0;
        end else if (r_lamp_cnt != LC_W'(LAMP_CYCLES)) begin
            r_lamp_cnt <= r_lamp_cnt + LC_W'(1);
        end
    end

    // Plausibility counter: length of the current HV/AIR disagreement while operating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else if (w_run && w_mismatch) begin
            if (r_pc != PC_W'(PLAUS_CYCLES)) r_pc <= r_pc + PC_W'(1);
        end else begin
            r_pc <= '0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LAMP;
        else      r_state <= w_next;
    end

    // Next-state logic; fault entry outranks the SAFE/ACTIVE swap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LAMP: begin
                if (r_lamp_cnt >= LC_W'(LAMP_CYCLES))
                    w_next = r_db[HV] ? S_ACTIVE : S_SAFE;
            end
            S_SAFE, S_ACTIVE: begin
                if (!r_db[SNS] || w_pc_hit)
                    w_next = S_FAULT;
                else if (r_state == S_SAFE && r_db[HV])
                    w_next = S_ACTIVE;
                else if (r_state == S_ACTIVE && !r_db[HV])
                    w_next = S_SAFE;
            end
            S_FAULT: begin
                if (fault_clr && r_db[SNS] && !w_mismatch)
                    w_next = r_db[HV] ? S_ACTIVE : S_SAFE;
            end
            default: w_next = S_LAMP;
        endcase
    end

    // Registered outputs decoded from the next state so they track the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_ctrl   <= 1'b0;
            green_ctrl <= 1'b0;
            fault      <= 1'b0;
        end else begin
            red_ctrl   <= (w_next == S_LAMP) || (w_next == S_ACTIVE);
            green_ctrl <= (w_next == S_LAMP) || (w_next == S_SAFE);
            fault      <= (w_next == S_FAULT);
        end
    end

endmodule
